// File: rtl/md_sched_pkg.sv
// md_sched_pkg: shared state encoding and status constants for the mult/div scheduler.
package md_sched_pkg;
  typedef enum logic [1:0] {IDLE, START, BUSY, HOLD} state_t;
  localparam int         MD_TIMEOUT_CYCLES = 64;
  localparam logic [4:0] RSTATUS_REG       = 5'd30;
  localparam logic [31:0] RSTATUS_MULT     = 32'd4;
  localparam logic [31:0] RSTATUS_DIV      = 32'd5;
  function automatic logic [31:0] status_code(input logic is_div);
    return is_div ? RSTATUS_DIV : RSTATUS_MULT;
  endfunction
endpackage

// File: rtl/md_wb_arbiter.sv
// md_wb_arbiter: regfile write-port mux; the W stage always wins over the scheduler.
module md_wb_arbiter (
  input  logic        w_we,
  input  logic [4:0]  w_rd,
  input  logic [31:0] w_data,
  input  logic        s_we,
  input  logic [4:0]  s_rd,
  input  logic [31:0] s_data,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data
);
  logic use_s;
  always_comb begin
    use_s   = !w_we && s_we;
    rf_we   = w_we || s_we;
    rf_rd   = use_s ? s_rd : w_rd;
    rf_data = use_s ? s_data : w_data;
  end
endmodule

// File: rtl/md_sched.sv
// md_sched: mult/div issue/complete scheduler with W-stage write arbitration.
// Optional watchdog enabled by defining MD_TIMEOUT_EN.
module md_sched
  import md_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [4:0]  issue_rd,
  output logic        md_start_mult,
  output logic        md_start_div,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  input  logic        w_we,
  input  logic [4:0]  w_rd,
  input  logic [31:0] w_data,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic        stall,
  output logic        timeout_flag
);
  state_t      state_q, state_d;
  logic        is_div_q, is_div_d;
  logic [4:0]  rd_q, rd_d;
  logic        hold_we_q, hold_we_d;
  logic [4:0]  hold_rd_q, hold_rd_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic        start_mult_q, start_div_q;
  logic        tmo, fire, exc, c_we, s_we;
  logic [4:0]  c_rd, s_rd;
  logic [31:0] c_data, s_data;

`ifdef MD_TIMEOUT_EN
  logic [6:0] cnt_q, cnt_d;
  logic       flag_q, flag_d;
  always_comb begin
    tmo    = state_q == BUSY && !md_ready && cnt_q == 7'(MD_TIMEOUT_CYCLES - 1);
    cnt_d  = (state_q == BUSY && !md_ready && !tmo) ? cnt_q + 7'd1 : 7'd0;
    flag_d = flag_q || tmo;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  assign timeout_flag = flag_q;
`else
  assign tmo          = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    fire   = state_q == BUSY && (md_ready || tmo);
    exc    = md_exception || tmo;
    c_rd   = exc ? RSTATUS_REG : rd_q;
    c_data = exc ? status_code(is_div_q) : md_result;
    c_we   = c_rd != 5'd0;
    // Writes that lose to the W stage are parked and retried from HOLD
    s_we   = !w_we && ((fire && c_we) || (state_q == HOLD && hold_we_q));
    s_rd   = state_q == HOLD ? hold_rd_q : c_rd;
    s_data = state_q == HOLD ? hold_data_q : c_data;
    hold_we_d   = (fire && w_we) ? c_we : hold_we_q;
    hold_rd_d   = (fire && w_we) ? c_rd : hold_rd_q;
    hold_data_d = (fire && w_we) ? c_data : hold_data_q;
    is_div_d = (state_q == IDLE && issue_valid) ? issue_is_div : is_div_q;
    rd_d     = (state_q == IDLE && issue_valid) ? issue_rd : rd_q;
    state_d  = state_q;
    case (state_q)
      IDLE:  state_d = issue_valid ? START : IDLE;
      START: state_d = BUSY;
      BUSY:  state_d = fire ? (w_we ? HOLD : IDLE) : BUSY;
      HOLD:  state_d = w_we ? HOLD : IDLE;
    endcase
    stall = state_q != IDLE || issue_valid;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      is_div_q     <= 1'b0;
      rd_q         <= '0;
      hold_we_q    <= 1'b0;
      hold_rd_q    <= '0;
      hold_data_q  <= '0;
      start_mult_q <= 1'b0;
      start_div_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_div_q     <= is_div_d;
      rd_q         <= rd_d;
      hold_we_q    <= hold_we_d;
      hold_rd_q    <= hold_rd_d;
      hold_data_q  <= hold_data_d;
      start_mult_q <= state_d == START && !is_div_d;
      start_div_q  <= state_d == START && is_div_d;
    end

  assign md_start_mult = start_mult_q;
  assign md_start_div  = start_div_q;

  md_wb_arbiter u_arb (
    .w_we(w_we), .w_rd(w_rd), .w_data(w_data),
    .s_we(s_we), .s_rd(s_rd), .s_data(s_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data)
  );
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed test of md_sched against an op-lifecycle model plus literal checks.
module tb_md_sched;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        issue_valid = 0, issue_is_div = 0;
  logic [4:0]  issue_rd = 0;
  logic        md_start_mult, md_start_div;
  logic        md_ready = 0, md_exception = 0;
  logic [31:0] md_result = 0;
  logic        w_we = 0;
  logic [4:0]  w_rd = 0;
  logic [31:0] w_data = 0;
  logic        rf_we, stall, timeout_flag;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  int checks = 0, errors = 0;
  int wr_n = 0, nmult = 0, ndiv = 0;
  logic [4:0]  last_rd = 0;
  logic [31:0] last_data = 0;

  always #5 clk = ~clk;

  md_sched dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_is_div(issue_is_div),
    .issue_rd(issue_rd), .md_start_mult(md_start_mult), .md_start_div(md_start_div),
    .md_ready(md_ready), .md_exception(md_exception), .md_result(md_result),
    .w_we(w_we), .w_rd(w_rd), .w_data(w_data), .rf_we(rf_we), .rf_rd(rf_rd),
    .rf_data(rf_data), .stall(stall), .timeout_flag(timeout_flag)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Model: op phase 0 none, 1 pulse due, 2 waiting for result, 3 result parked
  int          m_op = 0, m_cnt = 0;
  logic        m_div = 0, m_flag = 0;
  logic [4:0]  m_rd = 0, m_prd = 0;
  logic [31:0] m_pdata = 0;
  logic        e_tmo, e_fire, e_exc, e_cwe, e_we;
  logic [4:0]  e_crd, e_rd;
  logic [31:0] e_cdata, e_data;

  always_comb begin
`ifdef MD_TIMEOUT_EN
    e_tmo = m_op == 2 && m_cnt == 63 && !md_ready;
`else
    e_tmo = 1'b0;
`endif
    e_fire  = m_op == 2 && (md_ready || e_tmo);
    e_exc   = md_exception || e_tmo;
    e_crd   = e_exc ? 5'd30 : m_rd;
    e_cdata = e_exc ? (m_div ? 32'd5 : 32'd4) : md_result;
    e_cwe   = e_crd != 0;
    e_we = 1'b0; e_rd = 0; e_data = 0;
    if (w_we) begin
      e_we = 1'b1; e_rd = w_rd; e_data = w_data;
    end else if (e_fire && e_cwe) begin
      e_we = 1'b1; e_rd = e_crd; e_data = e_cdata;
    end else if (m_op == 3 && m_prd != 0) begin
      e_we = 1'b1; e_rd = m_prd; e_data = m_pdata;
    end
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_op <= 0; m_cnt <= 0; m_flag <= 0;
    end else begin
      if (e_tmo) m_flag <= 1'b1;
      if (m_op == 0 && issue_valid) begin
        m_op <= 1; m_div <= issue_is_div; m_rd <= issue_rd;
      end else if (m_op == 1) begin
        m_op <= 2; m_cnt <= 0;
      end else if (m_op == 2) begin
        m_cnt <= m_cnt + 1;
        if (e_fire) begin
          m_op <= w_we ? 3 : 0;
          m_prd <= e_cwe ? e_crd : 5'd0;
          m_pdata <= e_cdata;
        end
      end else if (m_op == 3 && !w_we) m_op <= 0;
    end

  always @(negedge clk) begin
    chk("rf_we", {31'b0, rf_we}, {31'b0, e_we});
    if (e_we) begin
      chk("rf_rd", {27'b0, rf_rd}, {27'b0, e_rd});
      chk("rf_data", rf_data, e_data);
    end
    chk("stall", {31'b0, stall}, {31'b0, m_op != 0 || issue_valid});
    chk("start_mult", {31'b0, md_start_mult}, {31'b0, m_op == 1 && !m_div});
    chk("start_div", {31'b0, md_start_div}, {31'b0, m_op == 1 && m_div});
    chk("timeout_flag", {31'b0, timeout_flag}, {31'b0, m_flag});
    if (rf_we && !w_we) begin
      wr_n++; last_rd = rf_rd; last_data = rf_data;
    end
    if (md_start_mult) nmult++;
    if (md_start_div) ndiv++;
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic div, input logic [4:0] rd, input int dly,
                        input logic exc, input logic [31:0] res, input int wc);
    issue_valid = 1; issue_is_div = div; issue_rd = rd;
    step;
    issue_valid = 0;
    repeat (dly) step;
    md_ready = 1; md_exception = exc; md_result = res;
    w_we = wc > 0; w_rd = 7; w_data = 32'hAAAA_0007;
    step;
    md_ready = 0; md_exception = 0;
    for (int i = 1; i < wc; i++) step;
    w_we = 0;
    step; step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step; step;
    @(negedge clk);
    chk("reset_rf_we", {31'b0, rf_we}, 32'd0);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    rst_n = 1;
    step;
    run_op(1'b0, 5'd3, 32, 1'b0, 32'hDEAD_0003, 0);
    chk("mult_pulses", nmult, 1);
    chk("mult_writes", wr_n, 1);
    chk("mult_rd", {27'b0, last_rd}, 3);
    chk("mult_data", last_data, 32'hDEAD_0003);
    run_op(1'b1, 5'd5, 10, 1'b1, 32'h1111_1111, 0);
    chk("div_pulses", ndiv, 1);
    chk("div_writes", wr_n, 2);
    chk("div_exc_rd", {27'b0, last_rd}, 30);
    chk("div_exc_data", last_data, 5);
    run_op(1'b0, 5'd9, 5, 1'b0, 32'h0000_1234, 2);
    chk("hold_writes", wr_n, 3);
    chk("hold_rd", {27'b0, last_rd}, 9);
    chk("hold_data", last_data, 32'h1234);
    run_op(1'b0, 5'd0, 4, 1'b0, 32'h5555_5555, 0);
    chk("rd0_writes", wr_n, 3);
    @(negedge clk);
    chk("rd0_idle_stall", {31'b0, stall}, 0);
    step;
    issue_valid = 1; issue_is_div = 1; issue_rd = 12;
    step;
    issue_valid = 0;
    repeat (3) step;
    rst_n = 0;
    @(negedge clk);
    chk("rst_rf_we", {31'b0, rf_we}, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_start", {30'b0, md_start_mult, md_start_div}, 0);
    issue_valid = 1;
    @(negedge clk);
    chk("rst_stall_iv", {31'b0, stall}, 1);
    issue_valid = 0;
    step;
    rst_n = 1;
    md_ready = 1; md_result = 32'h7777_7777;
    step;
    md_ready = 0;
    step; step;
    chk("rst_no_write", wr_n, 3);
`ifdef MD_TIMEOUT_EN
    issue_valid = 1; issue_is_div = 0; issue_rd = 3;
    step;
    issue_valid = 0;
    repeat (64) step;
    @(negedge clk);
    chk("tmo_rf_we", {31'b0, rf_we}, 1);
    chk("tmo_rd", {27'b0, rf_rd}, 30);
    chk("tmo_data", rf_data, 4);
    repeat (5) step;
    chk("tmo_flag_held", {31'b0, timeout_flag}, 1);
`endif
    step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 SHALL have port clock, input, 1: master clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low; 0 forces reset state immediately.
REQ-003 SHALL have port issue_valid, input, 1: X stage holds a mult/div; sampled only in IDLE.
REQ-004 SHALL have port issue_is_div, input, 1: 1 for div, 0 for mult.
REQ-005 SHALL have port issue_rd, input, 5: destination register of the issued op.
REQ-006 SHALL have ports md_start_mult and md_start_div, output, 1 each: one-cycle start pulses to the multdiv unit.
REQ-007 SHALL have ports md_ready, md_exception, input, 1 each, and md_result, input, 32: multdiv completion, error flag and product/quotient.
REQ-008 SHALL have ports w_we, input, 1; w_rd, input, 5; w_data, input, 32: W-stage regfile write request.
REQ-009 SHALL have ports rf_we, output, 1; rf_rd, output, 5; rf_data, output, 32: arbitrated regfile write port.
REQ-010 SHALL have port stall, output, 1: freezes PC, FD and DX.
REQ-011 SHALL have port timeout_flag, output, 1: sticky watchdog indicator (MD_TIMEOUT_EN only; tied 0 otherwise).

Function
REQ-012 SHALL implement states IDLE, START, BUSY, HOLD.
REQ-013 IDLE with issue_valid=1 SHALL latch issue_is_div and issue_rd and go to START next cycle; issue_valid is ignored in every other state.
REQ-014 START SHALL assert exactly one of md_start_mult/md_start_div for that single cycle, then go to BUSY.
REQ-015 BUSY with md_ready=1 and w_we=0 SHALL drive the result onto rf_* that same cycle and go to IDLE.
REQ-016 BUSY with md_ready=1 and w_we=1 SHALL capture result/exception into a hold buffer and go to HOLD; W stage always has write-port priority.
REQ-017 HOLD SHALL drive the buffered write in the first cycle with w_we=0, then go to IDLE.
REQ-018 While the W stage owns the port, rf_we/rf_rd/rf_data SHALL equal w_we/w_rd/w_data unmodified.
REQ-019 A normal completion SHALL write md_result to the latched rd; rd=0 SHALL suppress rf_we for the scheduler's write.
REQ-020 A completion with md_exception=1 SHALL instead write r30 with 4 (mult) or 5 (div).
REQ-021 stall SHALL be combinational: 1 when (IDLE and issue_valid) or in START, BUSY or HOLD; 0 otherwise, including the completion cycle's successor.
REQ-022 Start pulses SHALL be registered outputs; no start pulse SHALL occur outside START.

Reset
REQ-023 Reset SHALL force IDLE; start pulses, rf_we, timeout_flag, latched rd, hold buffer and watchdog count to 0; stall then follows REQ-021.
REQ-024 Reset mid-operation (START/BUSY/HOLD) SHALL discard the pending op with no regfile write; a later md_ready SHALL be ignored in IDLE.

Configuration
REQ-025 With MD_TIMEOUT_EN defined, a counter SHALL count BUSY cycles; on reaching MD_TIMEOUT_CYCLES without md_ready, the op SHALL complete as an exception (REQ-020 codes), set timeout_flag and go to IDLE (via HOLD if w_we=1).
REQ-026 With MD_TIMEOUT_EN defined, timeout_flag SHALL stay 1 until reset.
REQ-027 Without MD_TIMEOUT_EN, no counter SHALL exist, BUSY SHALL wait indefinitely for md_ready and timeout_flag SHALL be constant 0.

Structure
REQ-028 A shared package SHALL hold the state encoding, MD_TIMEOUT_CYCLES (64), RSTATUS_REG (30), RSTATUS_MULT (4) and RSTATUS_DIV (5).
REQ-029 The write-port mux (W versus scheduler) SHALL be a sub-module named md_wb_arbiter; FSM, buffer and watchdog stay in md_sched.

Verification
REQ-030 Mult to rd=3, md_ready 32 cycles after the pulse, w_we=0: one md_start_mult pulse, stall high through completion, r3 gets the result that cycle.
REQ-031 Div to rd=5 with md_exception=1: rf_rd=30, rf_data=5, no write to r5.
REQ-032 md_ready while w_we=1 (w_rd=7) for 2 cycles: W writes r7 twice, then the buffered result is written, then IDLE.
REQ-033 Mult to rd=0 completes: rf_we stays 0 from the scheduler, FSM returns to IDLE.
REQ-034 Reset low during BUSY, then md_ready pulses: no regfile write, all outputs 0, stall follows issue_valid.
REQ-035 MD_TIMEOUT_EN, mult with md_ready never asserted: after 64 BUSY cycles rf_rd=30, rf_data=4, timeout_flag=1 and held.
